urv_uart_tx: RTL

Memory-mapped UART transmitter on the uRV CPU data-memory bus, downstream of the core's dm_* interface.
- Replaces the bare byte latch at I/O address 0x0001_0000.
- Stores push bytes into a TX FIFO, which drains through an 8N1 serializer.
- Status and divider registers are readable through the same load/store handshake the core already uses.

---
 rtl/urv_uart_tx.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/urv_uart_tx.sv
// Memory-mapped 8N1 UART transmitter for the uRV data bus.
// Holds TXDATA/STATUS/DIVIDER registers and a byte FIFO that feeds the serializer.
module urv_uart_tx #(
    parameter logic [31:0] g_base_addr       = 32'h0001_0000,
    parameter int          g_fifo_depth_log2 = 4,
    parameter logic [15:0] g_clk_div_default = 16'd867
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic        txd_o,
    output logic        irq_o
);
    localparam int c_depth = 2 ** g_fifo_depth_log2;
    localparam int c_pw    = g_fifo_depth_log2 + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    function automatic logic [15:0] merge_bytes(input logic [15:0] old_v,
                                                input logic [15:0] new_v,
                                                input logic [1:0]  sel);
        merge_bytes = old_v;
        if (sel[0]) merge_bytes[7:0]  = new_v[7:0];
        if (sel[1]) merge_bytes[15:8] = new_v[15:8];
    endfunction

    logic [7:0]      mem_r [c_depth];
    logic [c_pw-1:0] wr_ptr_r, rd_ptr_r, level_s;
    logic            empty_s, full_s;
    logic            hit_s, wr_txdata_s, wr_status_s, wr_div_s;
    logic            pop_s, push_ok_s, ovf_set_s, bit_end_s;
    logic            ovf_r;
    logic [15:0]     div_r, cnt_r;
    logic [7:0]      sh_r;
    logic [2:0]      bit_idx_r;
    state_t          state_r;
    logic            txd_r;
    logic [31:0]     rdata_s, data_l_r;
    logic            store_done_r, load_done_r;
    logic            unused_s;

    assign unused_s    = ^{dm_data_s_i[31:16], dm_data_select_i[3:2]};
    assign hit_s       = (dm_addr_i[31:4] == g_base_addr[31:4]);
    assign wr_txdata_s = dm_store_i && hit_s && (dm_addr_i[3:0] == 4'h0) && dm_data_select_i[0];
    assign wr_status_s = dm_store_i && hit_s && (dm_addr_i[3:0] == 4'h4) && dm_data_select_i[0];
    assign wr_div_s    = dm_store_i && hit_s && (dm_addr_i[3:0] == 4'h8);

    assign level_s   = wr_ptr_r - rd_ptr_r;
    assign empty_s   = (level_s == {c_pw{1'b0}});
    assign full_s    = (level_s == c_pw'(c_depth));
    assign bit_end_s = (cnt_r == 16'd0);
    // The serializer also pops at the end of STOP so consecutive frames abut.
    assign pop_s     = !empty_s && ((state_r == ST_IDLE) || ((state_r == ST_STOP) && bit_end_s));
    assign push_ok_s = wr_txdata_s && (!full_s || pop_s);
    assign ovf_set_s = wr_txdata_s && full_s && !pop_s;

    assign irq_o           = empty_s && (state_r == ST_IDLE);
    assign txd_o           = txd_r;
    assign dm_data_l_o     = data_l_r;
    assign dm_store_done_o = store_done_r;
    assign dm_load_done_o  = load_done_r;

    // FIFO storage, no reset needed since pointers qualify every entry
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[g_fifo_depth_log2-1:0]] <= dm_data_s_i[7:0];
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_r <= {c_pw{1'b0}};
            rd_ptr_r <= {c_pw{1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + c_pw'(1);
            if (pop_s)     rd_ptr_r <= rd_ptr_r + c_pw'(1);
        end
    end

    // Control registers: sticky overflow and bit-time divider
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_r <= 1'b0;
            div_r <= g_clk_div_default;
        end else begin
            if (ovf_set_s)                         ovf_r <= 1'b1;
            else if (wr_status_s && dm_data_s_i[3]) ovf_r <= 1'b0;
            if (wr_div_s) div_r <= merge_bytes(div_r, dm_data_s_i[15:0], dm_data_select_i[1:0]);
        end
    end

    // Register read mux
    always_comb begin
        rdata_s = 32'd0;
        case (dm_addr_i[3:0])
            4'h4: begin
                rdata_s[8 +: c_pw] = level_s;
                rdata_s[3:0]       = {ovf_r, (state_r != ST_IDLE), empty_s, full_s};
            end
            4'h8:    rdata_s[15:0] = div_r;
            default: rdata_s = 32'd0;
        endcase
    end

    // Bus acknowledge and registered load data
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            store_done_r <= 1'b0;
            load_done_r  <= 1'b0;
            data_l_r     <= 32'd0;
        end else begin
            store_done_r <= dm_store_i && hit_s;
            load_done_r  <= dm_load_i && hit_s;
            data_l_r     <= (dm_load_i && hit_s) ? rdata_s : 32'd0;
        end
    end

    // Serializer: every state lasts div_r+1 clocks, reloaded only at bit boundaries
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            sh_r      <= 8'd0;
            bit_idx_r <= 3'd0;
            txd_r     <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        sh_r    <= mem_r[rd_ptr_r[g_fifo_depth_log2-1:0]];
                        cnt_r   <= div_r;
                        txd_r   <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        txd_r <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        cnt_r     <= div_r;
                        bit_idx_r <= 3'd0;
                        txd_r     <= sh_r[0];
                        state_r   <= ST_DATA;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        cnt_r <= div_r;
                        if (bit_idx_r == 3'd7) begin
                            txd_r   <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            sh_r      <= {1'b0, sh_r[7:1]};
                            txd_r     <= sh_r[1];
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        if (pop_s) begin
                            sh_r    <= mem_r[rd_ptr_r[g_fifo_depth_log2-1:0]];
                            cnt_r   <= div_r;
                            txd_r   <= 1'b0;
                            state_r <= ST_START;
                        end else begin
                            txd_r   <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    txd_r   <= 1'b1;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
